// File: rtl/timeslot_scheduler_pkg.sv
// Shared definitions for the time-slot scheduler: FSM state encodings and
// default geometry used when the scheduler is instantiated without overrides.
package timeslot_scheduler_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timeslot_scheduler_slot_counter.sv
// Slot length counter: up counter with synchronous clear taking priority
// over enable. The scheduler holds it cleared whenever no slot is running.
module slot_counter
  import timeslot_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  // Count register: clear wins over enable so a release never leaves a stale value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out <= '0;
    else if (clr) out <= '0;
    else if (en)  out <= out + 1'b1;
  end

endmodule

// File: rtl/timeslot_scheduler.sv
// Round-robin time-slot scheduler sharing one slot counter among NREQ
// requesters. A granted requester owns the slot for LEN+1 cycles or until it
// drops its request; the slot then ends with a one-cycle DONE pulse.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no owner, counter held at 0, pick next requester after LAST
//   S_RUN  | owner holds GRANT, counter advances until terminal or drop
//   S_DONE | DONE pulse on the previous owner's bit, counter cleared
module timeslot_scheduler
  import timeslot_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      count,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] l_q, l_d;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] len_sel;
  logic             cnt_clr, cnt_en;

  // First requester found scanning last+1, last+2, ... modulo NREQ. Walking
  // the offsets from farthest to nearest lets the nearest hit overwrite.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] sel;
    logic [IW-1:0] k;
    sel = last;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % NREQ);
      if (r[k]) sel = k;
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, last_q);

  // Length field of the requester that would be granted this cycle.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (IW'(i) == pick) len_sel = len[i*WIDTH +: WIDTH];
  end

  // Next-state and counter control; the counter is cleared outside RUN.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    last_d  = last_q;
    idx_d   = idx_q;
    l_d     = l_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (|req) begin
          idx_d   = pick;
          grant_d = ONE << pick;
          l_d     = len_sel;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Terminal count and owner drop share one release path, so a
        // coincident pair still yields a single DONE pulse.
        if (count == l_q || !req[idx_q]) begin
          grant_d = '0;
          done_d  = ONE << idx_q;
          last_d  = idx_q;
          cnt_clr = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; LAST resets so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      last_q  <= IW'(NREQ - 1);
      idx_q   <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      l_q     <= l_d;
    end
  end

  slot_counter #(.WIDTH(WIDTH)) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .out   (count)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_timeslot_scheduler.sv
// Scoreboard bench for timeslot_scheduler: the driver predicts each slot
// (owner, length in cycles, idle gap before it) from the round-robin and
// slot-length rules and queues it; the monitor pops on every new grant and
// checks the slot as it plays out.
module tb_timeslot_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  count;
  logic        busy;

  always #50 clk = ~clk;

  timeslot_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  typedef struct {
    int owner;
    int dur;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_last;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: first requester after the previous owner, wrapping around.
  function automatic int rr_owner(input logic [3:0] r, input int last);
    int k;
    for (int off = 1; off <= NREQ; off++) begin
      k = (last + off) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Monitor
  int   cyc = 0;
  int   last_done_cyc = -100;
  int   run = 0;
  bit   active = 1'b0;
  bit   after_done = 1'b0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active     = 1'b0;
        after_done = 1'b0;
      end else begin
        chk("grant_onehot0", int'($onehot0(grant)), 1);
        chk("grant_done_excl", int'(|(grant & done)), 0);
        if (after_done) begin
          chk("done_one_cycle", int'(done), 0);
          chk("busy_after_done", int'(busy), 0);
          after_done = 1'b0;
        end else if (done != 4'b0) begin
          if (active) begin
            chk("done_owner", int'(done), 1 << cur.owner);
            chk("slot_len", run, cur.dur);
            chk("count_cleared", int'(count), 0);
          end else begin
            chk("unexpected_done", int'(done), 0);
          end
          active        = 1'b0;
          last_done_cyc = cyc;
          after_done    = 1'b1;
        end
        if (grant != 4'b0) begin
          if (!active) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_grant", int'(grant), 0);
            end else begin
              cur    = exp_q.pop_front();
              active = 1'b1;
              run    = 0;
              chk("grant_owner", int'(grant), 1 << cur.owner);
              if (cur.gap >= 0) chk("grant_gap", cyc - last_done_cyc, cur.gap);
            end
          end
          if (active) begin
            chk("grant_hold", int'(grant), 1 << cur.owner);
            chk("count_seq", int'(count), run);
            chk("busy_run", int'(busy), 1);
            run++;
          end
        end else if (active && done == 4'b0) begin
          chk("release_without_done", 0, 1);
          active = 1'b0;
        end
      end
    end
  end

  // One slot: predict, drive, optionally drop the owner at a given count,
  // optionally scramble non-owner requests and LEN while the slot runs.
  task automatic run_slot(input logic [3:0] rp, input logic [15:0] lp,
                          input int drop_at, input int gap,
                          input bit perturb, input int lenmod_at);
    int own, l, dur;
    bit dropped, seen;
    logic [3:0] om;
    own = rr_owner(rp, m_last);
    l   = int'(lp[own*4 +: 4]);
    dur = (drop_at >= 0 && drop_at < l) ? drop_at + 1 : l + 1;
    exp_q.push_back('{own, dur, gap});
    m_last  = own;
    om      = 4'b0001 << own;
    req     = rp;
    len     = lp;
    dropped = 1'b0;
    seen    = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk); #1;
      if (grant != 4'b0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      chk("grant_timeout", 0, 1);
      req = '0;
      return;
    end
    seen = 1'b0;
    for (int t = 0; t < 24; t++) begin
      if (!dropped && drop_at >= 0 && int'(count) == drop_at) dropped = 1'b1;
      if (perturb) begin
        req = (4'($urandom) & ~om) | (dropped ? 4'b0 : om);
        len = 16'($urandom);
      end else if (dropped) begin
        req = rp & ~om;
      end
      if (int'(count) == lenmod_at) len[own*4 +: 4] = 4'd2;
      @(negedge clk); #1;
      if (grant == 4'b0) begin seen = 1'b1; break; end
    end
    if (!seen) chk("release_timeout", 0, 1);
    req = '0;
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, own, drop;
    bit found;
    logic [3:0] rp;

    // Reset held with all requesters active
    rst_n = 1'b1;
    req   = 4'hF;
    len   = 16'($urandom);
    #10 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_grant", int'(grant), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
    end
    req = '0;
    @(negedge clk); #5 rst_n = 1'b1;
    m_last = NREQ - 1;

    // Fairness: all requesting, every slot one cycle
    len = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      own = rr_owner(4'hF, m_last);
      exp_q.push_back('{own, 1, (i == 0) ? -1 : 2});
      m_last = own;
    end
    req = 4'hF;
    nd  = 0;
    for (int t = 0; t < 30 && nd < 5; t++) begin
      @(negedge clk); #1;
      if (done != 4'b0) nd++;
    end
    req = '0;
    chk("fair_done_count", nd, 5);
    repeat (2) @(negedge clk);
    #1;

    // Single slot, early release at count 5, full length with LEN change
    run_slot(4'b0010, 16'h0030, -1, -1, 1'b0, -1);
    run_slot(4'b0100, 16'h0F00,  5,  2, 1'b0, -1);
    run_slot(4'b1000, 16'hF000, -1,  2, 1'b0,  3);

    // Async reset in the middle of a slot
    len = 16'h000F;
    own = rr_owner(4'b0011, m_last);
    exp_q.push_back('{own, 16, -1});
    m_last = own;
    req   = 4'b0011;
    found = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk); #1;
      if (grant != 4'b0 && count == 4'd7) begin found = 1'b1; break; end
    end
    chk("rst_mid_reach7", int'(found), 1);
    #20 rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", int'(grant), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    m_last = NREQ - 1;
    len    = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      own = rr_owner(4'b0011, m_last);
      exp_q.push_back('{own, 1, (i == 0) ? -1 : 2});
      m_last = own;
    end
    @(negedge clk); #5 rst_n = 1'b1;
    nd = 0;
    for (int t = 0; t < 20 && nd < 2; t++) begin
      @(negedge clk); #1;
      if (done != 4'b0) nd++;
    end
    req = '0;
    chk("rst_after_done_count", nd, 2);
    repeat (2) @(negedge clk);
    #1;

    // Randomized slots with scrambled non-owner requests and LEN
    for (int i = 0; i < 30; i++) begin
      rp   = 4'($urandom_range(1, 15));
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_slot(rp, 16'($urandom), drop, (i == 0) ? -1 : 2, 1'b1, -1);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("no_open_slot", int'(active), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
